// File: rtl/captura_teclado.sv
// Keypad front-end for the ATM controller: forwards PIN digits one at a time,
// or accumulates decimal digits into a binary amount that is committed on ENTER.
module captura_teclado #(
  parameter int MAX_DIGITOS = 9,
  parameter int ANCHO_MONTO = 32
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   TECLA_STB,
  input  logic [3:0]             TECLA,
  input  logic                   MODO_MONTO,
  output logic                   DIGITO_STB,
  output logic [3:0]             DIGITO,
  output logic                   MONTO_STB,
  output logic [ANCHO_MONTO-1:0] MONTO,
  output logic [3:0]             CONT_DIGITOS,
  output logic                   CANCELADO,
  output logic                   TECLA_ERR
);

  typedef enum logic {VACIO, CAPTURANDO} estado_t;
  typedef enum logic [2:0] {K_DIGITO, K_ENTER, K_BORRAR, K_CANCELAR, K_INVALIDA} clase_t;

  localparam logic [3:0]             MAX_CONT = 4'(MAX_DIGITOS);
  localparam logic [ANCHO_MONTO-1:0] DIEZ     = ANCHO_MONTO'(10);

  estado_t                state, state_base, state_next;
  logic [ANCHO_MONTO-1:0] acc, acc_base, acc_next, acc_x10, acc_div10;
  logic [3:0]             cont, cont_base, cont_next;
  logic                   modo_prev, modo_cambio, cont_ok;
  clase_t                 clase;

  logic                   digito_stb_next, monto_stb_next, cancelado_next, tecla_err_next;
  logic [3:0]             digito_next;
  logic [ANCHO_MONTO-1:0] monto_next;

  always_comb begin
    if (TECLA <= 4'd9) clase = K_DIGITO;
    else begin
      case (TECLA)
        4'hA:    clase = K_ENTER;
        4'hB:    clase = K_BORRAR;
        4'hC:    clase = K_CANCELAR;
        default: clase = K_INVALIDA;
      endcase
    end
  end

  // A mode change clears the entry first; a key in the same cycle then acts on the cleared state.
  assign modo_cambio = (MODO_MONTO != modo_prev);
  assign state_base  = modo_cambio ? VACIO : state;
  assign acc_base    = modo_cambio ? '0 : acc;
  assign cont_base   = modo_cambio ? 4'd0 : cont;
  assign cont_ok     = (cont_base < MAX_CONT);

  assign acc_x10   = (acc_base << 3) + (acc_base << 1) + ANCHO_MONTO'(TECLA);
  assign acc_div10 = acc_base / DIEZ;

  // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_next = state_base;
    acc_next   = acc_base;
    cont_next  = cont_base;
    if (TECLA_STB && MODO_MONTO) begin
      case (clase)
        K_DIGITO: if (cont_ok) begin
          acc_next   = acc_x10;
          cont_next  = cont_base + 4'd1;
          state_next = CAPTURANDO;
        end
        K_ENTER: if (state_base == CAPTURANDO) begin
          acc_next   = '0;
          cont_next  = 4'd0;
          state_next = VACIO;
        end
        K_BORRAR: if (state_base == CAPTURANDO) begin
          acc_next   = acc_div10;
          cont_next  = cont_base - 4'd1;
          if (cont_base == 4'd1) state_next = VACIO;
        end
        K_CANCELAR: begin
          acc_next   = '0;
          cont_next  = 4'd0;
          state_next = VACIO;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    digito_stb_next = 1'b0;
    monto_stb_next  = 1'b0;
    cancelado_next  = 1'b0;
    tecla_err_next  = 1'b0;
    digito_next     = DIGITO;
    monto_next      = MONTO;
    if (TECLA_STB) begin
      if (!MODO_MONTO) begin
        case (clase)
          K_DIGITO: begin
            digito_stb_next = 1'b1;
            digito_next     = TECLA;
          end
          K_CANCELAR: cancelado_next = 1'b1;
          K_INVALIDA: tecla_err_next = 1'b1;
          default: ;
        endcase
      end else begin
        case (clase)
          K_DIGITO: tecla_err_next = !cont_ok;
          K_ENTER: begin
            if (state_base == CAPTURANDO) begin
              monto_stb_next = 1'b1;
              monto_next     = acc_base;
            end else begin
              tecla_err_next = 1'b1;
            end
          end
          K_CANCELAR: cancelado_next = 1'b1;
          K_INVALIDA: tecla_err_next = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= VACIO;
      acc        <= '0;
      cont       <= 4'd0;
      modo_prev  <= 1'b0;
      DIGITO_STB <= 1'b0;
      DIGITO     <= 4'd0;
      MONTO_STB  <= 1'b0;
      MONTO      <= '0;
      CANCELADO  <= 1'b0;
      TECLA_ERR  <= 1'b0;
    end else begin
      state      <= state_next;
      acc        <= acc_next;
      cont       <= cont_next;
      modo_prev  <= MODO_MONTO;
      DIGITO_STB <= digito_stb_next;
      DIGITO     <= digito_next;
      MONTO_STB  <= monto_stb_next;
      MONTO      <= monto_next;
      CANCELADO  <= cancelado_next;
      TECLA_ERR  <= tecla_err_next;
    end
  end

  assign CONT_DIGITOS = cont;

endmodule
